tx_timer_param: RTL and testbench
=================================

Name: tx_timer_param

Overview:
- Parametrised bit/word/frame timing generator for the Ethernet TX serializer path.
- Produces one-cycle `shift_en` strobes at a programmable clock-divided bit rate.
- Signals word completion after `BITS_PER_WORD` strobes and frame completion after a programmable word count.
- Supports pause and synchronous clear; drives the TX shift register and the TX framing FSM.

Parameters:
- DIV_W, 8, width of the clocks-per-bit divisor input.
- BITS_PER_WORD, 8, `shift_en` strobes per word (≥2).
- WORD_W, 11, width of the words-per-frame input and word counter (up to 2047 words).

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- clear  in  1  synchronous abort; highest priority
- pause  in  1  freeze all counters, suppress strobes
- clks_per_bit  in  DIV_W  bit period in clocks; latched on start; 0 treated as 1
- words_per_frame  in  WORD_W  frame length in words; latched on start; 0 = continuous, no frame_done
- busy  out  1  high in RUN state
- shift_en  out  1  one-cycle bit strobe
- word_done  out  1  coincident with last `shift_en` of each word
- frame_done  out  1  coincident with last `word_done` of the frame
- bit_idx  out  clog2(BITS_PER_WORD)  index of the next bit to shift
- word_cnt  out  WORD_W  completed words in the current frame

Behaviour:
- States: IDLE, RUN. Reset → IDLE; every counter and output is 0.
- IDLE → RUN: start=1 and clear=0.
  - Latches `div_n = max(clks_per_bit, 1)` and `frame_len = words_per_frame`.
  - Zeroes div_cnt, bit_idx, word_cnt.
- In RUN with pause=0, div_cnt increments and wraps at div_n−1.
- `shift_en = RUN & !pause & (div_cnt == div_n−1)`, combinational from registers.
- Start at cycle t: busy=1 from t+1; first shift_en at cycle t+div_n.
  - With div_n=1, shift_en is high every unpaused RUN cycle from t+1.
- bit_idx increments on each shift_en and wraps to 0 after BITS_PER_WORD−1.
  - `word_done = shift_en & (bit_idx == BITS_PER_WORD−1)`.
- word_cnt increments on word_done.
  - `frame_done = word_done & (frame_len != 0) & (word_cnt == frame_len−1)`.
  - On frame_done: RUN → IDLE next cycle; counters cleared; word_cnt reads 0 in IDLE.
- frame_len = 0: word_cnt wraps modulo 2^WORD_W; RUN persists until clear.
- pause=1: div_cnt, bit_idx, word_cnt hold; shift_en, word_done, frame_done forced 0.
  - Resuming continues from the held div_cnt; no phase is lost or repeated.
- clear=1 in any state: next cycle IDLE, all counters 0. Same cycle, strobes are masked to 0.
  - clear overrides start and pause.
- start while in RUN is ignored; clks_per_bit and words_per_frame changes mid-frame are ignored.
- Async reset mid-frame: immediate IDLE; all outputs 0.

Optional Feature:
- Macro: `TX_TIMER_PARITY_EN`.
- Defined:
  - Each word spans BITS_PER_WORD+1 strobes.
  - Extra output `parity_slot` (1 bit) = shift_en during the final strobe (bit_idx == BITS_PER_WORD).
  - word_done moves to that final strobe.
  - bit_idx width becomes clog2(BITS_PER_WORD+1).
- Undefined: no parity_slot port; word = BITS_PER_WORD strobes.

Decomposition:
- Package `tx_timer_pkg`: `tx_timer_state_t` enum {IDLE, RUN}; default constants for DIV_W, BITS_PER_WORD, WORD_W.
- Sub-module `tx_clk_div`: loadable modulo-N divider with enable, sync clear, and terminal-count output; instantiated once for div_cnt.
- Bit and word counters stay inline.

Test Plan:
- Reset/idle: n_rst low 3 cycles, then idle 20 cycles → busy, shift_en, word_done, frame_done all 0; bit_idx=0, word_cnt=0.
- Basic frame: clks_per_bit=4, words_per_frame=2, start at cycle 10 →
  - shift_en at cycles 14, 18, …, 74 (16 strobes);
  - word_done at 42 and 74; frame_done at 74;
  - busy low from 75.
- Divisor 0/1: clks_per_bit=0, words_per_frame=1 → shift_en high 8 consecutive cycles from t+1; frame_done on the 8th.
- Pause: clks_per_bit=4, pause high for 5 cycles right after the 3rd strobe → strobes 4–16 delayed exactly 5 cycles; no extra or missing strobe.
- Clear mid-frame: assert clear with start in the same cycle after word 1 → IDLE next cycle, counters 0, no frame_done; a new start runs a full fresh frame.
- Continuous plus parity (macro defined): words_per_frame=0, clks_per_bit=2 →
  - parity_slot every 18th cycle;
  - word_cnt wraps 2047→0 with no frame_done;
  - clear stops operation.

Source files
------------

// File: rtl/tx_timer_pkg.sv
// tx_timer_pkg: shared state type and default sizing for the TX bit/word/frame timer
package tx_timer_pkg;
  typedef enum logic {IDLE, RUN} tx_timer_state_t;
  localparam int DEF_DIV_W = 8;
  localparam int DEF_BITS_PER_WORD = 8;
  localparam int DEF_WORD_W = 11;
endpackage

// File: rtl/tx_clk_div.sv
// tx_clk_div: loadable modulo-N divider (clk, n_rst, clr, load, en, div -> tc); div of 0 loads as 1
module tx_clk_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         tc
);
  logic [W-1:0] n_q, n_d, cnt_q, cnt_d;
  assign tc = cnt_q == n_q - W'(1);
  always_comb begin
    n_d = clr ? '0 : load ? (div == '0 ? W'(1) : div) : n_q;
    cnt_d = (clr | load) ? '0 : en ? (tc ? '0 : cnt_q + W'(1)) : cnt_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      n_q <= '0;
      cnt_q <= '0;
    end else begin
      n_q <= n_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tx_timer_param.sv
// tx_timer_param: bit/word/frame strobe generator for the Ethernet TX serializer
// in: clk, n_rst, start, clear, pause, clks_per_bit, words_per_frame
// out: busy, shift_en, word_done, frame_done, bit_idx, word_cnt (+ parity_slot with TX_TIMER_PARITY_EN)
module tx_timer_param import tx_timer_pkg::*; #(
  parameter int DIV_W = DEF_DIV_W,
  parameter int BITS_PER_WORD = DEF_BITS_PER_WORD,
  parameter int WORD_W = DEF_WORD_W,
`ifdef TX_TIMER_PARITY_EN
  localparam int SLOTS = BITS_PER_WORD + 1,
`else
  localparam int SLOTS = BITS_PER_WORD,
`endif
  localparam int IW = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              clear,
  input  logic              pause,
  input  logic [DIV_W-1:0]  clks_per_bit,
  input  logic [WORD_W-1:0] words_per_frame,
  output logic              busy,
  output logic              shift_en,
  output logic              word_done,
  output logic              frame_done,
  output logic [IW-1:0]     bit_idx,
  output logic [WORD_W-1:0] word_cnt
`ifdef TX_TIMER_PARITY_EN
  ,output logic             parity_slot
`endif
);
  localparam logic [IW-1:0] LAST = IW'(SLOTS - 1);
  tx_timer_state_t state_q, state_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [WORD_W-1:0] word_q, word_d, len_q, len_d;
  logic run, tc, last_bit;
  assign run = state_q == RUN;
  // clear masks strobes in the same cycle it is asserted
  assign shift_en = run & ~pause & ~clear & tc;
  assign last_bit = bit_q == LAST;
  assign word_done = shift_en & last_bit;
  assign frame_done = word_done & (len_q != '0) & (word_q == len_q - WORD_W'(1));
  assign busy = run;
  assign bit_idx = bit_q;
  assign word_cnt = word_q;
`ifdef TX_TIMER_PARITY_EN
  assign parity_slot = word_done;
`endif
  tx_clk_div #(.W(DIV_W)) u_div (
    .clk(clk),
    .n_rst(n_rst),
    .clr(clear | frame_done),
    .load(~run & start & ~clear),
    .en(run & ~pause),
    .div(clks_per_bit),
    .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    word_d = word_q;
    len_d = len_q;
    if (clear || frame_done) begin
      state_d = IDLE;
      bit_d = '0;
      word_d = '0;
    end else if (!run) begin
      if (start) begin
        state_d = RUN;
        len_d = words_per_frame;
        bit_d = '0;
        word_d = '0;
      end
    end else if (shift_en) begin
      bit_d = last_bit ? '0 : bit_q + IW'(1);
      word_d = word_q + WORD_W'(word_done);
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      word_q <= '0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      word_q <= word_d;
      len_q <= len_d;
    end
endmodule

// File: tb/tb_tx_timer_param.sv
// tb_tx_timer_param: randomized and directed checks of tx_timer_param against a strobe-counting model
module tb_tx_timer_param;
  localparam int BPW = 8;
  localparam int WORD_W = 11;
`ifdef TX_TIMER_PARITY_EN
  localparam int NB = BPW + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = BPW;
  localparam bit PAR = 1'b0;
`endif
  localparam int IW = $clog2(NB);
  localparam int VW = 5 + IW + WORD_W;
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, clear = 1'b0, pause = 1'b0;
  logic [7:0] clks_per_bit = '0;
  logic [WORD_W-1:0] words_per_frame = '0;
  logic busy, shift_en, word_done, frame_done, par;
  logic [IW-1:0] bit_idx;
  logic [WORD_W-1:0] word_cnt;
  int checks = 0, passed = 0;
  bit m_run = 1'b0;
  int m_div = 1, m_len = 0, m_active = 0, m_strobes = 0;
  always #5 clk = ~clk;
  tx_timer_param dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .clear(clear),
    .pause(pause),
    .clks_per_bit(clks_per_bit),
    .words_per_frame(words_per_frame),
    .busy(busy),
    .shift_en(shift_en),
    .word_done(word_done),
    .frame_done(frame_done),
    .bit_idx(bit_idx),
    .word_cnt(word_cnt)
`ifdef TX_TIMER_PARITY_EN
    ,.parity_slot(par)
`endif
  );
`ifndef TX_TIMER_PARITY_EN
  assign par = 1'b0;
`endif
  function automatic logic [VW-1:0] obs();
    return {busy, shift_en, word_done, frame_done, par, bit_idx, word_cnt};
  endfunction
  // model: m_active unpaused RUN cycles and m_strobes strobes seen since start
  function automatic logic [VW-1:0] model_exp();
    bit s, wd, fd, p;
    int k;
    s = m_run && !pause && !clear && ((m_active + 1) % m_div == 0);
    k = m_strobes + 1;
    wd = s && (k % NB == 0);
    fd = wd && m_len != 0 && (k / NB == m_len);
    p = PAR && s && (m_strobes % NB == BPW);
    return {m_run, s, wd, fd, p, IW'(m_strobes % NB), WORD_W'(m_strobes / NB)};
  endfunction
  task automatic tick();
    logic [VW-1:0] e;
    e = model_exp();
    if (clear) begin
      m_run = 1'b0; m_active = 0; m_strobes = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1'b1; m_div = clks_per_bit == 0 ? 1 : int'(clks_per_bit);
        m_len = int'(words_per_frame); m_active = 0; m_strobes = 0;
      end
    end else if (e[VW-4]) begin
      m_run = 1'b0; m_active = 0; m_strobes = 0;
    end else if (!pause) begin
      m_active++;
      if (e[VW-2]) m_strobes++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs() !== '0) $display("FAIL reset_hold got=%h exp=0", obs()); else passed++;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checks++;
      if (obs() !== model_exp()) $display("FAIL reset_idle n=%0d got=%h exp=%h", n, obs(), model_exp()); else passed++;
      tick();
    end
  endtask
  task automatic test_basic();
    int nse = 0, nwd = 0, fd_at = -1, idle_at = -1;
    clks_per_bit = 8'd4; words_per_frame = 11'd2;
    for (int n = 0; n < 80; n++) begin
      start = n == 0;
      @(negedge clk);
      checks++;
      if (obs() !== model_exp()) $display("FAIL basic n=%0d got=%h exp=%h", n, obs(), model_exp()); else passed++;
      nse += int'(shift_en); nwd += int'(word_done);
      if (frame_done) fd_at = n;
      if (n > 0 && !busy && idle_at < 0) idle_at = n;
      tick();
    end
    start = 1'b0;
    checks++;
    if (nse != 2 * NB || nwd != 2) $display("FAIL basic_count strobes=%0d words=%0d exp %0d/2", nse, nwd, 2 * NB); else passed++;
    checks++;
    if (fd_at != 8 * NB || idle_at != 8 * NB + 1) $display("FAIL basic_timing fd=%0d idle=%0d exp %0d/%0d", fd_at, idle_at, 8 * NB, 8 * NB + 1); else passed++;
  endtask
  task automatic test_div0();
    logic [15:0] mask = '0, emask;
    int fd_at = -1;
    emask = 16'(((1 << NB) - 1) << 1);
    clks_per_bit = 8'd0; words_per_frame = 11'd1;
    for (int n = 0; n < 14; n++) begin
      start = n == 0;
      @(negedge clk);
      checks++;
      if (obs() !== model_exp()) $display("FAIL div0 n=%0d got=%h exp=%h", n, obs(), model_exp()); else passed++;
      mask[n] = shift_en;
      if (frame_done) fd_at = n;
      tick();
    end
    start = 1'b0;
    checks++;
    if (mask !== emask || fd_at != NB) $display("FAIL div0_run mask=%h fd=%0d exp %h/%0d", mask, fd_at, emask, NB); else passed++;
  endtask
  task automatic test_pause();
    int nse = 0, s4 = -1, fd_at = -1;
    clks_per_bit = 8'd4; words_per_frame = 11'd2;
    for (int n = 0; n < 85; n++) begin
      start = n == 0;
      pause = n >= 13 && n <= 17;
      @(negedge clk);
      checks++;
      if (obs() !== model_exp()) $display("FAIL pause n=%0d got=%h exp=%h", n, obs(), model_exp()); else passed++;
      if (shift_en) begin nse++; if (nse == 4) s4 = n; end
      if (frame_done) fd_at = n;
      tick();
    end
    start = 1'b0; pause = 1'b0;
    checks++;
    if (nse != 2 * NB || s4 != 21 || fd_at != 8 * NB + 5) $display("FAIL pause_shift strobes=%0d s4=%0d fd=%0d exp %0d/21/%0d", nse, s4, fd_at, 2 * NB, 8 * NB + 5); else passed++;
  endtask
  task automatic test_clear();
    int fdn = 0, fd_at = -1;
    clks_per_bit = 8'd2; words_per_frame = 11'd3;
    for (int n = 0; n < 24; n++) begin
      start = n == 0 || n == 20;
      clear = n == 20;
      @(negedge clk);
      checks++;
      if (obs() !== model_exp()) $display("FAIL clear n=%0d got=%h exp=%h", n, obs(), model_exp()); else passed++;
      fdn += int'(frame_done);
      tick();
    end
    clear = 1'b0;
    checks++;
    if (fdn != 0 || busy !== 1'b0 || word_cnt !== '0) $display("FAIL clear_abort fd=%0d busy=%b wc=%0d exp 0/0/0", fdn, busy, word_cnt); else passed++;
    for (int n = 0; n < 6 * NB + 4; n++) begin
      start = n == 0;
      @(negedge clk);
      checks++;
      if (obs() !== model_exp()) $display("FAIL clear_fresh n=%0d got=%h exp=%h", n, obs(), model_exp()); else passed++;
      if (frame_done) fd_at = n;
      tick();
    end
    start = 1'b0;
    checks++;
    if (fd_at != 6 * NB) $display("FAIL clear_fresh_fd got=%0d exp=%0d", fd_at, 6 * NB); else passed++;
  endtask
  task automatic test_continuous();
    int len, wraps = 0, fdn = 0, pn = 0, wdn = 0;
    logic [WORD_W-1:0] prev = '0;
    len = 2048 * NB * 2 + 20;
    clks_per_bit = 8'd2; words_per_frame = 11'd0;
    for (int n = 0; n < len + 6; n++) begin
      start = n == 0;
      clear = n == len;
      @(negedge clk);
      checks++;
      if (obs() !== model_exp()) $display("FAIL cont n=%0d got=%h exp=%h", n, obs(), model_exp()); else passed++;
      if (busy && prev == 11'd2047 && word_cnt == 11'd0) wraps++;
      prev = word_cnt;
      fdn += int'(frame_done); pn += int'(par); wdn += int'(word_done);
      tick();
    end
    start = 1'b0; clear = 1'b0;
    checks++;
    if (wraps != 1 || fdn != 0 || busy !== 1'b0) $display("FAIL cont_wrap wraps=%0d fd=%0d busy=%b exp 1/0/0", wraps, fdn, busy); else passed++;
    checks++;
    if (pn != (PAR ? wdn : 0) || wdn != 2048 + 1) $display("FAIL cont_parity par=%0d words=%0d exp %0d/2049", pn, wdn, PAR ? wdn : 0); else passed++;
  endtask
  task automatic test_async_reset();
    clks_per_bit = 8'd3; words_per_frame = 11'd2;
    for (int n = 0; n < 30; n++) begin
      start = n == 0;
      @(negedge clk);
      checks++;
      if (obs() !== model_exp()) $display("FAIL arst_run n=%0d got=%h exp=%h", n, obs(), model_exp()); else passed++;
      tick();
    end
    start = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) $display("FAIL arst_now got=%h exp=0", obs()); else passed++;
    m_run = 1'b0; m_active = 0; m_strobes = 0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (obs() !== model_exp()) $display("FAIL arst_idle n=%0d got=%h exp=%h", n, obs(), model_exp()); else passed++;
      tick();
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < 400; n++) begin
        clks_per_bit = 8'($urandom_range(0, 5));
        words_per_frame = 11'($urandom_range(0, 3));
        start = $urandom_range(0, 7) == 0;
        pause = $urandom_range(0, 4) == 0;
        clear = $urandom_range(0, 79) == 0 || n == 399;
        @(negedge clk);
        checks++;
        if (obs() !== model_exp()) $display("FAIL random it=%0d n=%0d got=%h exp=%h", it, n, obs(), model_exp()); else passed++;
        tick();
      end
    end
    start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_div0();
    test_pause();
    test_clear();
    test_continuous();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
